// File: rtl/aes_cipher_round.sv
// Iterative AES-128 encryption round engine.
// One round is applied per accepted round key from the key expander.
module aes_cipher_round #(
  parameter int NR = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [31:0] data0_in,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  input  logic [31:0] data3_in,
  input  logic [31:0] rkey0_in,
  input  logic [31:0] rkey1_in,
  input  logic [31:0] rkey2_in,
  input  logic [31:0] rkey3_in,
  input  logic        rk_valid_in,
  output logic        key_start_out,
  output logic [31:0] data0_out,
  output logic [31:0] data1_out,
  output logic [31:0] data2_out,
  output logic [31:0] data3_out,
  output logic        done_out,
  output logic        busy_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ROUND0    = 2'd1,
    ROUND1TO9 = 2'd2,
    ROUND10   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q;
  logic [127:0] st_q;
  logic [127:0] dout_q;
  logic [127:0] din, rk;
  logic [127:0] ss, r0_res, full_res, fin_res;
  logic         accept, step;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    case (x)
      8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b;
      8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
      8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b;
      8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
      8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d;
      8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
      8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf;
      8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
      8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26;
      8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
      8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1;
      8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
      8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3;
      8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
      8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2;
      8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
      8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a;
      8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
      8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3;
      8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
      8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed;
      8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
      8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39;
      8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
      8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb;
      8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
      8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f;
      8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
      8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f;
      8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
      8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21;
      8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
      8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec;
      8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
      8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d;
      8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
      8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc;
      8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
      8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14;
      8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
      8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a;
      8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
      8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62;
      8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
      8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d;
      8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
      8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea;
      8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
      8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e;
      8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
      8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f;
      8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
      8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66;
      8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
      8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9;
      8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
      8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11;
      8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
      8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9;
      8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
      8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d;
      8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
      8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f;
      8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
    endcase
    return y;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Byte (col c, row r) lives at bit 127-8*(4c+r); row r pulls from col c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]),
            mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  assign din      = {data0_in, data1_in, data2_in, data3_in};
  assign rk       = {rkey0_in, rkey1_in, rkey2_in, rkey3_in};
  assign ss       = sub_shift(st_q);
  assign r0_res   = st_q ^ rk;
  assign full_res = mix(ss) ^ rk;
  assign fin_res  = ss ^ rk;

  assign accept = start_in && (state_q == IDLE);
  assign step   = rk_valid_in && (state_q != IDLE);

  assign key_start_out = accept && RST;
  assign state_out     = state_q;
  assign data0_out     = dout_q[127:96];
  assign data1_out     = dout_q[95:64];
  assign data2_out     = dout_q[63:32];
  assign data3_out     = dout_q[31:0];

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_in) state_d = ROUND0;
      ROUND0:    if (rk_valid_in) state_d = ROUND1TO9;
      ROUND1TO9: if (rk_valid_in && rnd_q == 4'(NR - 1)) state_d = ROUND10;
      ROUND10:   if (rk_valid_in) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      st_q     <= '0;
      rnd_q    <= '0;
      dout_q   <= '0;
      done_out <= 1'b0;
      busy_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (accept) begin
        st_q     <= din;
        rnd_q    <= '0;
        busy_out <= 1'b1;
      end else if (step) begin
        rnd_q <= rnd_q + 4'd1;
        unique case (state_q)
          ROUND0:    st_q <= r0_res;
          ROUND1TO9: st_q <= full_res;
          ROUND10: begin
            st_q     <= fin_res;
            dout_q   <= fin_res;
            done_out <= 1'b1;
            busy_out <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_cipher_round.sv
// Bench for aes_cipher_round: acts as the key expander and
// compares against an AES-128 model built from GF(2^8) arithmetic.
module tb_aes_cipher_round;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start_in = 1'b0;
  logic        rk_valid_in = 1'b0;
  logic [31:0] data0_in, data1_in, data2_in, data3_in;
  logic [31:0] rkey0_in, rkey1_in, rkey2_in, rkey3_in;
  logic        key_start_out, done_out, busy_out;
  logic [31:0] data0_out, data1_out, data2_out, data3_out;
  logic [1:0]  state_out;
  logic [127:0] dout;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk_g [11];
  logic [127:0] last_ct = '0;

  aes_cipher_round #(.NR(10)) dut (
    .CLK(CLK), .RST(RST), .start_in(start_in),
    .data0_in(data0_in), .data1_in(data1_in),
    .data2_in(data2_in), .data3_in(data3_in),
    .rkey0_in(rkey0_in), .rkey1_in(rkey1_in),
    .rkey2_in(rkey2_in), .rkey3_in(rkey3_in),
    .rk_valid_in(rk_valid_in), .key_start_out(key_start_out),
    .data0_out(data0_out), .data1_out(data1_out),
    .data2_out(data2_out), .data3_out(data3_out),
    .done_out(done_out), .busy_out(busy_out), .state_out(state_out)
  );

  assign dout = {data0_out, data1_out, data2_out, data3_out};

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box = affine map of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                  ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] key, input logic [127:0] pt,
                       output logic [127:0] ct);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [7:0]   a [4];
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]],
             sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk_g[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int k = 0; k < 16; k++)
      s[k] = pt[127-8*k -: 8] ^ rk_g[0][127-8*k -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int w8 = 0; w8 < 4; w8++)
          n[4*c+w8] = sbox_t[s[4*((c+w8)%4)+w8]];
      s = n;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int q = 0; q < 4; q++) a[q] = s[4*c+q];
          for (int q = 0; q < 4; q++)
            s[4*c+q] = gmul(a[q], 8'h02) ^ gmul(a[(q+1)%4], 8'h03)
                       ^ a[(q+2)%4] ^ a[(q+3)%4];
        end
      end
      for (int k = 0; k < 16; k++) s[k] ^= rk_g[r][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) ct[127-8*k -: 8] = s[k];
  endtask

  function automatic int exp_state(input int done_rounds);
    if (done_rounds == 0) return 1;
    if (done_rounds <= 9) return 2;
    return 3;
  endfunction

  // Drives one encryption from the current negedge; returns at the
  // negedge where done_out is expected (or after an abort reset).
  task automatic run_enc(input logic [127:0] key, input logic [127:0] pt,
                         input logic [127:0] ct_exp, input int stall_at,
                         input int nstall, input int spur_at,
                         input int abort_at);
    logic [127:0] ct_m;
    int i, n, stalled;
    model(key, pt, ct_m);
    start_in = 1'b1;
    {data0_in, data1_in, data2_in, data3_in} = pt;
    #1;
    chk("key_start_pulse", key_start_out, 1);
    chk("idle_state", state_out, 0);
    @(posedge CLK); @(negedge CLK);
    start_in = 1'b0;
    i = 0; n = 1; stalled = 0;
    while (i < 11 && n < 40) begin
      chk("state_seq", state_out, exp_state(i));
      chk("busy_high", busy_out, 1);
      chk("done_low", done_out, 0);
      chk("out_held", dout, last_ct);
      if (abort_at == i) begin
        RST = 1'b0;
        rk_valid_in = 1'b0;
        @(posedge CLK); @(negedge CLK);
        chk("abort_state", state_out, 0);
        chk("abort_out", dout, 0);
        chk("abort_done", done_out, 0);
        chk("abort_busy", busy_out, 0);
        chk("abort_kstart", key_start_out, 0);
        RST = 1'b1;
        last_ct = '0;
        return;
      end
      if (spur_at == i) begin
        start_in = 1'b1;
        {data0_in, data1_in, data2_in, data3_in} =
          {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("spur_kstart", key_start_out, 0);
      end
      if (i == stall_at && stalled < nstall) begin
        rk_valid_in = 1'b0;
        stalled++;
      end else begin
        rk_valid_in = 1'b1;
        {rkey0_in, rkey1_in, rkey2_in, rkey3_in} = rk_g[i];
      end
      @(posedge CLK);
      if (rk_valid_in) i++;
      @(negedge CLK);
      start_in = 1'b0;
      n++;
    end
    rk_valid_in = 1'b0;
    chk("done_pulse", done_out, 1);
    chk("latency", 128'(n), 128'(12 + nstall));
    chk("ciphertext", dout, ct_exp);
    chk("model_ct", dout, ct_m);
    chk("busy_fall", busy_out, 0);
    chk("state_idle", state_out, 0);
    last_ct = ct_exp;
  endtask

  task automatic idle_check();
    @(posedge CLK); @(negedge CLK);
    chk("done_once", done_out, 0);
    chk("out_kept", dout, last_ct);
    chk("idle_after", state_out, 0);
  endtask

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] rk, rp, rc;
    build_sbox();
    {data0_in, data1_in, data2_in, data3_in} = '0;
    {rkey0_in, rkey1_in, rkey2_in, rkey3_in} = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_state", state_out, 0);
    chk("rst_out", dout, 0);
    chk("rst_done", done_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_kstart", key_start_out, 0);
    RST = 1'b1;

    run_enc(KB, PB, CB, -1, 0, -1, -1);
    idle_check();
    run_enc(KC, PC, CC, -1, 0, -1, -1);
    idle_check();
    run_enc('0, '0, CZ, -1, 0, -1, -1);
    idle_check();
    run_enc(KB, PB, CB, 5, 3, -1, -1);
    idle_check();
    run_enc(KC, PC, CC, -1, 0, 3, -1);
    idle_check();
    run_enc(KC, PC, CC, -1, 0, -1, 6);
    idle_check();
    run_enc(KB, PB, CB, -1, 0, -1, -1);
    run_enc(KC, PC, CC, -1, 0, -1, -1);
    idle_check();

    for (int t = 0; t < 4; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      model(rk, rp, rc);
      run_enc(rk, rp, rc, (t == 1) ? 2 : -1, (t == 1) ? 2 : 0, -1, -1);
    end
    idle_check();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_cipher_round.md
Name: aes_cipher_round

Overview:
- Iterative AES-128 encryption datapath that sits directly downstream of the key-expansion stage.
- Consumes one 128-bit round key per cycle as four 32-bit words and applies one AES round per accepted key.
- Rounds: AddRoundKey, then 9 full rounds, then a final round without MixColumns.
- Emits the ciphertext with a one-cycle done pulse. It also drives the key expander's start so the two stay aligned.

Parameters:
- NR, 10, number of rounds after the initial AddRoundKey. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-low reset
- start_in  in  1  request encryption of data*_in; sampled only in IDLE
- data0_in..data3_in  in  32 each  plaintext; word c = state column c, bits[31:24] = row 0
- rkey0_in..rkey3_in  in  32 each  current round key from the key expander, same byte order as data
- rk_valid_in  in  1  rkey*_in holds the key for the current round
- key_start_out  out  1  one-cycle pulse to the key expander's start input
- data0_out..data3_out  out  32 each  ciphertext; registered; held until the next accepted start
- done_out  out  1  one-cycle pulse: data*_out has just become valid
- busy_out  out  1  high from start acceptance until done_out
- state_out  out  2  FSM state: 0 IDLE, 1 ROUND0, 2 ROUND1to9, 3 ROUND10

Behaviour:
- Reset: clock and reset are a single clock with a synchronous, active-low reset. With RST=0 at a rising edge, the following clear to 0:
  - state register, round counter (4 bits), data*_out
  - key_start_out, done_out, busy_out
  - the FSM goes to IDLE
- Reset mid-operation aborts the encryption. No done_out is produced.
- IDLE:
  - If start_in=1 at an edge: latch data*_in into the 128-bit state register, set round=0, go to ROUND0, set busy_out=1.
  - key_start_out=1 combinationally in that same cycle (start_in & IDLE).
- Round step: in every non-IDLE state, an edge with rk_valid_in=1 performs one round on the state register using rkey*_in and increments round. An edge with rk_valid_in=0 holds all registers (stall).
- Per-round operation:
  - ROUND0 (round=0): state ^= key.
  - ROUND1to9 (round 1..9): SubBytes → ShiftRows → MixColumns → ^key.
  - ROUND10 (round=10): SubBytes → ShiftRows → ^key.
- Transitions:
  - ROUND0 → ROUND1to9 after the round-0 step.
  - ROUND1to9 stays until the step at round=9, then → ROUND10.
  - ROUND10 → IDLE after its step.
- Completion: on the ROUND10 step edge, write the result into data*_out as well.
  - done_out=1 for exactly the following cycle, and busy_out falls in that same cycle.
- Latency: start accepted at edge T with rk_valid_in continuously 1 afterwards:
  - rounds 0..10 occur at edges T+1..T+11
  - done_out is high in the cycle after edge T+11
  - minimum 12 cycles from start to done; each stall cycle adds one.
- start_in is ignored while busy_out=1; no queuing.
- Back-to-back: start_in may be accepted in the same cycle done_out is high (FSM already IDLE).
- SubBytes:
  - 16 parallel forward S-box lookups; the S-box is implemented as a combinational case ROM.
- ShiftRows:
  - Row r rotates left by r columns, so new column c, row r = old column (c+r) mod 4, row r.
- MixColumns:
  - Standard matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8).
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
  - All arithmetic is 8-bit XOR; no carries.
- data*_out is not updated during operation; it keeps the previous ciphertext until the next done_out.

Test Plan:
- FIPS-197 App. B: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, pt 3243f6a8 885a308d 313198a2 e0370734, rk_valid_in=1 always → key_start_out pulse at start; done_out exactly 12 cycles after start; out 3925841d 02dc09fb dc118597 196a0b32.
- FIPS-197 C.1: key 00010203…0c0d0e0f, pt 00112233…ccddeeff → 69c4e0d8 6a7b0430 d8cdb780 70b4c55a; state_out sequence 0,1,2×9,3,0.
- All-zero key and plaintext → 66e94bd4 ef8a2c3b 884cfa59 ca342b2e.
- Stall: App. B vectors with rk_valid_in deasserted 3 cycles after round 4 → same ciphertext; done_out at 15 cycles; state and round held during stall.
- Robustness: start_in pulsed while busy_out=1 → ignored, no extra key_start_out, ciphertext unchanged.
- Robustness: RST=0 at round 6 → next cycle all outputs 0, state_out=0, no done_out; a fresh start afterwards gives the correct App. B result.
- Back-to-back: second start in the done cycle → second done 12 cycles later; first ciphertext held until then.
